hdc_hs_perf_monitor: RTL and testbench
======================================

// Module: hdc_hs_perf_monitor
// PURPOSE
// - Synthesizable, parametrised on-chip monitor for the valid/ready handshakes around hdc_sensor_fusion.
// - Passively taps fin_* and dout_*; never drives them.
// - Counts stall/idle cycles per side and accepted entries, and timestamps each accepted input.
// - Measures per-entry latency (last/min/max/total) and runs until a programmed entry count is reached.
// PARAMETERS
// - CNT_WIDTH     32  width of all event counters and total_latency
// - TS_WIDTH      16  width of cycle timestamp and latency values
// - MAX_INFLIGHT  8   timestamp FIFO depth (power of 2, >=2)
// - NUM_LABELS    2   label bits on dout side (valence, arousal, ...)
// PORTS
// - clk            in   1                 clock
// - rst            in   1                 asynchronous, active-high reset
// - start          in   1                 pulse: IDLE->RUN
// - clear          in   1                 pulse: zero all stats, ->IDLE (sync, highest priority)
// - target_entries in   CNT_WIDTH         run ends when dout_accepts == this (0 = never)
// - fin_valid      in   1                 tap
// - fin_ready      in   1                 tap
// - dout_valid     in   1                 tap
// - dout_ready     in   1                 tap
// - labels         in   NUM_LABELS        tap of DUT output labels
// - exp_labels     in   NUM_LABELS        expected labels (used only with HDC_PERF_LABEL_CHECK_EN)
// - running        out  1                 state==RUN
// - done           out  1                 state==DONE
// - fin_stall_cnt  out  CNT_WIDTH         cycles fin_valid & ~fin_ready
// - fin_idle_cnt   out  CNT_WIDTH         cycles ~fin_valid & fin_ready
// - dout_stall_cnt out  CNT_WIDTH         cycles dout_valid & ~dout_ready
// - dout_idle_cnt  out  CNT_WIDTH         cycles ~dout_valid & dout_ready
// - fin_accepts    out  CNT_WIDTH         fin handshakes
// - dout_accepts   out  CNT_WIDTH         dout handshakes
// - lat_last       out  TS_WIDTH          latency of most recent matched entry
// - lat_min        out  TS_WIDTH          minimum latency
// - lat_max        out  TS_WIDTH          maximum latency
// - lat_total      out  CNT_WIDTH         sum of latencies
// - mismatch_cnt   out  CNT_WIDTH         label mismatches (0 when feature off)
// - overflow       out  1                 sticky: push while FIFO full
// - underflow      out  1                 sticky: dout accept with no timestamp
// BEHAVIOUR
// - Reset/clear:
//   - All outputs 0, except lat_min = all-ones.
//   - State = IDLE; FIFO empty; cycle timer = 0.
// - FSM IDLE -> RUN on start.
// - FSM RUN -> DONE when the dout accept raises dout_accepts to target_entries (target != 0).
//   - That accept is counted.
// - DONE and IDLE hold all stats; start in DONE re-enters RUN without clearing.
// - Priority: clear > start.
// - Sampling happens only in RUN. Taps are sampled at posedge; counter updates are visible the next cycle (1-cycle latency).
// - Cycle timer: free-running in RUN, wraps mod 2^TS_WIDTH. Latency = pop_ts - push_ts (unsigned modulo), so it is correct for latencies < 2^TS_WIDTH.
// - fin accept (valid & ready) pushes the timestamp. dout accept pops the oldest timestamp and updates lat_last/min/max/total in the same edge.
// - Simultaneous push and pop:
//   - The pop uses the FIFO state before the push.
//   - FIFO empty: underflow is set, no latency update, and the push is still stored.
//   - FIFO full: the pop frees a slot and the push is stored with no overflow.
// - Push while full without a pop: the timestamp is dropped and overflow is set. fin_accepts still increments.
// - All counters saturate at all-ones; no wrap.
// - Async rst mid-run: immediate return to reset values; no partial update survives.
// CONFIGURATION
// - HDC_PERF_LABEL_CHECK_EN defined:
//   - On each dout accept in RUN, labels are compared with exp_labels.
//   - mismatch_cnt increments by the number of differing bits (popcount, saturating).
// - HDC_PERF_LABEL_CHECK_EN undefined:
//   - No comparator; mismatch_cnt is tied to 0.
//   - labels and exp_labels are unused.
// STRUCTURE
// - Package hdc_perf_pkg:
//   - cnt_t / ts_t typedefs built from the parameters' defaults.
//   - State enum {IDLE, RUN, DONE}.
//   - Function sat_inc().
// - Sub-module hdc_perf_ts_fifo: MAX_INFLIGHT x TS_WIDTH FIFO with push/pop, full/empty, and a pre-push read port.
// - Top holds the FSM, timer, counters and latency statistics.
// TESTING
// - Reset, start, target=4, 4 back-to-back entries with DUT latency fixed at 10:
//   -> dout_accepts=4, lat_min=lat_max=lat_last=10, lat_total=40, done=1 a cycle after the 4th accept.
// - fin_valid high, fin_ready low for 7 cycles, then accept:
//   -> fin_stall_cnt=7, fin_accepts=1; same pattern on the dout side -> dout_stall_cnt=7.
// - 9 fin accepts (MAX_INFLIGHT=8) with no dout -> overflow=1, fin_accepts=9.
//   Then drain 8 -> underflow=0; one extra dout accept -> underflow=1.
// - Pre-set timer to 0xFFFE, push, pop 5 cycles later -> lat_last=5 (wrap-around).
// - clear in the same cycle as start during RUN -> all stats 0, lat_min=0xFFFF, state IDLE.
//   rst asserted mid-entry -> same values immediately.
// - With HDC_PERF_LABEL_CHECK_EN: labels=2'b10, exp_labels=2'b01 -> mismatch_cnt=2.
//   Without it -> mismatch_cnt=0.

Source files
------------

// File: rtl/hdc_perf_pkg.sv
// Shared types and helpers for the hdc_sensor_fusion handshake monitor.
// Contents:
//   cnt_t / ts_t : default-width counter and timestamp types
//   state_e      : monitor run state (IDLE, RUN, DONE)
//   sat_inc()    : saturating add used by every statistic counter
package hdc_perf_pkg;

    localparam int CNT_WIDTH_DEF = 32;
    localparam int TS_WIDTH_DEF  = 16;

    typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;
    typedef logic [TS_WIDTH_DEF-1:0]  ts_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Adds inc to val and clamps at max_val. Counters narrower than cnt_t
    // pass their own all-ones value as max_val.
    function automatic cnt_t sat_inc(input cnt_t val, input cnt_t inc, input cnt_t max_val);
        logic [CNT_WIDTH_DEF:0] sum;
        sum = {1'b0, val} + {1'b0, inc};
        return (sum > {1'b0, max_val}) ? max_val : sum[CNT_WIDTH_DEF-1:0];
    endfunction

endpackage

// File: rtl/hdc_perf_ts_fifo.sv
// Timestamp FIFO holding the push time of every in-flight entry.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush_i           synchronous empty (wins over push/pop)
//   push_i/push_data  store push_data; accepted when not full or when popping
//   pop_i             drop the oldest entry; ignored when empty
//   head_data_o       oldest entry, read before this cycle's push
//   full_o, empty_o   occupancy flags
module hdc_perf_ts_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign head_data_o = mem_q[rd_ptr_q];

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign do_rd = pop_i & ~empty_o;
    assign do_wr = push_i & (~full_o | do_rd);

    // NOTE: storage has no reset; the pointers and count define validity,
    // so resetting the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_wr && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hdc_hs_perf_monitor.sv
// Passive performance monitor for the fin_* / dout_* valid-ready handshakes
// of hdc_sensor_fusion. Counts stall/idle cycles and accepts per side and
// measures per-entry latency (last/min/max/total) while in RUN.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, clear             run control (clear wins, synchronous)
//   target_entries           run stops after this many dout accepts (0 = never)
//   fin_*, dout_*, labels    observed taps; exp_labels = reference labels
//   running, done            state decode
//   *_cnt, *_accepts, lat_*  statistics (saturating)
//   overflow, underflow      sticky timestamp FIFO errors
// Build option: define HDC_PERF_LABEL_CHECK_EN to count label bit mismatches
// on each dout accept; otherwise mismatch_cnt is tied to zero.
// CNT_WIDTH must not exceed the package counter width (32).
module hdc_hs_perf_monitor
    import hdc_perf_pkg::*;
#(
    parameter int CNT_WIDTH    = 32,
    parameter int TS_WIDTH     = 16,
    parameter int MAX_INFLIGHT = 8,
    parameter int NUM_LABELS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic [CNT_WIDTH-1:0]  target_entries,
    input  logic                  fin_valid,
    input  logic                  fin_ready,
    input  logic                  dout_valid,
    input  logic                  dout_ready,
    input  logic [NUM_LABELS-1:0] labels,
    input  logic [NUM_LABELS-1:0] exp_labels,
    output logic                  running,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  fin_stall_cnt,
    output logic [CNT_WIDTH-1:0]  fin_idle_cnt,
    output logic [CNT_WIDTH-1:0]  dout_stall_cnt,
    output logic [CNT_WIDTH-1:0]  dout_idle_cnt,
    output logic [CNT_WIDTH-1:0]  fin_accepts,
    output logic [CNT_WIDTH-1:0]  dout_accepts,
    output logic [TS_WIDTH-1:0]   lat_last,
    output logic [TS_WIDTH-1:0]   lat_min,
    output logic [TS_WIDTH-1:0]   lat_max,
    output logic [CNT_WIDTH-1:0]  lat_total,
    output logic [CNT_WIDTH-1:0]  mismatch_cnt,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    function automatic logic [CNT_WIDTH-1:0] cnt_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [CNT_WIDTH-1:0] b);
        return CNT_WIDTH'(sat_inc(cnt_t'(a), cnt_t'(b), cnt_t'(CNT_MAX)));
    endfunction

    state_e               state_q;
    logic [TS_WIDTH-1:0]  timer_q, timer_d;
    logic [CNT_WIDTH-1:0] fin_stall_q, fin_stall_d, fin_idle_q, fin_idle_d;
    logic [CNT_WIDTH-1:0] dout_stall_q, dout_stall_d, dout_idle_q, dout_idle_d;
    logic [CNT_WIDTH-1:0] fin_acc_q, fin_acc_d, dout_acc_q, dout_acc_d;
    logic [TS_WIDTH-1:0]  lat_last_q, lat_last_d, lat_min_q, lat_min_d, lat_max_q, lat_max_d;
    logic [CNT_WIDTH-1:0] lat_total_q, lat_total_d;
    logic                 overflow_q, overflow_d, underflow_q, underflow_d;

    logic                 sampling, fin_hs, dout_hs;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TS_WIDTH-1:0]  fifo_head, lat;

    assign sampling = (state_q == RUN) & ~clear;
    assign fin_hs   = fin_valid & fin_ready;
    assign dout_hs  = dout_valid & dout_ready;

    // The pop sees the FIFO before this cycle's push, so an empty FIFO
    // underflows even if a push arrives on the same edge.
    assign fifo_pop  = sampling & dout_hs & ~fifo_empty;
    assign fifo_push = sampling & fin_hs & (~fifo_full | fifo_pop);
    assign lat       = timer_q - fifo_head;  // modulo 2^TS_WIDTH

    hdc_perf_ts_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TS_WIDTH)
    ) u_ts_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (clear),
        .push_i      (fifo_push),
        .push_data_i (timer_q),
        .pop_i       (fifo_pop),
        .head_data_o (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // NOTE: every next-state value is defaulted to its register first, so no
    // path through this block leaves a variable unassigned (no latches).
    always_comb begin
        timer_d      = timer_q;
        fin_stall_d  = fin_stall_q;
        fin_idle_d   = fin_idle_q;
        dout_stall_d = dout_stall_q;
        dout_idle_d  = dout_idle_q;
        fin_acc_d    = fin_acc_q;
        dout_acc_d   = dout_acc_q;
        lat_last_d   = lat_last_q;
        lat_min_d    = lat_min_q;
        lat_max_d    = lat_max_q;
        lat_total_d  = lat_total_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (clear) begin
            timer_d      = '0;
            fin_stall_d  = '0;
            fin_idle_d   = '0;
            dout_stall_d = '0;
            dout_idle_d  = '0;
            fin_acc_d    = '0;
            dout_acc_d   = '0;
            lat_last_d   = '0;
            lat_min_d    = '1;
            lat_max_d    = '0;
            lat_total_d  = '0;
            overflow_d   = 1'b0;
            underflow_d  = 1'b0;
        end else if (sampling) begin
            timer_d = timer_q + TS_WIDTH'(1);
            if (fin_valid & ~fin_ready)   fin_stall_d  = cnt_add(fin_stall_q, CNT_ONE);
            if (~fin_valid & fin_ready)   fin_idle_d   = cnt_add(fin_idle_q, CNT_ONE);
            if (dout_valid & ~dout_ready) dout_stall_d = cnt_add(dout_stall_q, CNT_ONE);
            if (~dout_valid & dout_ready) dout_idle_d  = cnt_add(dout_idle_q, CNT_ONE);
            if (fin_hs)  fin_acc_d  = cnt_add(fin_acc_q, CNT_ONE);
            if (dout_hs) dout_acc_d = cnt_add(dout_acc_q, CNT_ONE);
            if (fifo_pop) begin
                lat_last_d  = lat;
                lat_total_d = cnt_add(lat_total_q, CNT_WIDTH'(lat));
                if (lat < lat_min_q) lat_min_d = lat;
                if (lat > lat_max_q) lat_max_d = lat;
            end
            if (fin_hs & fifo_full & ~fifo_pop) overflow_d  = 1'b1;
            if (dout_hs & fifo_empty)           underflow_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            fin_stall_q  <= '0;
            fin_idle_q   <= '0;
            dout_stall_q <= '0;
            dout_idle_q  <= '0;
            fin_acc_q    <= '0;
            dout_acc_q   <= '0;
            lat_last_q   <= '0;
            lat_min_q    <= '1;
            lat_max_q    <= '0;
            lat_total_q  <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            fin_stall_q  <= fin_stall_d;
            fin_idle_q   <= fin_idle_d;
            dout_stall_q <= dout_stall_d;
            dout_idle_q  <= dout_idle_d;
            fin_acc_q    <= fin_acc_d;
            dout_acc_q   <= dout_acc_d;
            lat_last_q   <= lat_last_d;
            lat_min_q    <= lat_min_d;
            lat_max_q    <= lat_max_d;
            lat_total_q  <= lat_total_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            if (clear) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE:    if (start) state_q <= RUN;
                    // The accept that reaches the target is itself counted.
                    RUN:     if (dout_hs && target_entries != '0 && dout_acc_d == target_entries)
                                 state_q <= DONE;
                    DONE:    if (start) state_q <= RUN;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

`ifdef HDC_PERF_LABEL_CHECK_EN
    logic [CNT_WIDTH-1:0] mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q;
        if (clear)
            mismatch_d = '0;
        else if (sampling && dout_hs)
            mismatch_d = cnt_add(mismatch_q, CNT_WIDTH'($countones(labels ^ exp_labels)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mismatch_q <= '0;
        else     mismatch_q <= mismatch_d;
    end

    assign mismatch_cnt = mismatch_q;
`else
    logic unused_labels;
    assign unused_labels = ^{labels, exp_labels};
    assign mismatch_cnt  = '0;
`endif

    assign running        = (state_q == RUN);
    assign done           = (state_q == DONE);
    assign fin_stall_cnt  = fin_stall_q;
    assign fin_idle_cnt   = fin_idle_q;
    assign dout_stall_cnt = dout_stall_q;
    assign dout_idle_cnt  = dout_idle_q;
    assign fin_accepts    = fin_acc_q;
    assign dout_accepts   = dout_acc_q;
    assign lat_last       = lat_last_q;
    assign lat_min        = lat_min_q;
    assign lat_max        = lat_max_q;
    assign lat_total      = lat_total_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_hdc_hs_perf_monitor.sv
// Self-checking bench for hdc_hs_perf_monitor. A scoreboard records the
// cycle of every stored fin accept and, on each dout accept, queues the
// expected latency that lat_last must show after the edge.
module tb_hdc_hs_perf_monitor;
    localparam int CW = 32;
    localparam int TW = 16;
    localparam int MI = 8;
    localparam int NL = 2;

    logic          clk = 1'b0;
    logic          rst, start, clear;
    logic [CW-1:0] target_entries;
    logic          fin_valid, fin_ready, dout_valid, dout_ready;
    logic [NL-1:0] labels, exp_labels;
    logic          running, done, overflow, underflow;
    logic [CW-1:0] fin_stall_cnt, fin_idle_cnt, dout_stall_cnt, dout_idle_cnt;
    logic [CW-1:0] fin_accepts, dout_accepts, lat_total, mismatch_cnt;
    logic [TW-1:0] lat_last, lat_min, lat_max;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;
    int push_q[$];
    int exp_lat_q[$];

    hdc_hs_perf_monitor #(
        .CNT_WIDTH (CW), .TS_WIDTH (TW), .MAX_INFLIGHT (MI), .NUM_LABELS (NL)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .clear (clear),
        .target_entries (target_entries),
        .fin_valid (fin_valid), .fin_ready (fin_ready),
        .dout_valid (dout_valid), .dout_ready (dout_ready),
        .labels (labels), .exp_labels (exp_labels),
        .running (running), .done (done),
        .fin_stall_cnt (fin_stall_cnt), .fin_idle_cnt (fin_idle_cnt),
        .dout_stall_cnt (dout_stall_cnt), .dout_idle_cnt (dout_idle_cnt),
        .fin_accepts (fin_accepts), .dout_accepts (dout_accepts),
        .lat_last (lat_last), .lat_min (lat_min), .lat_max (lat_max),
        .lat_total (lat_total), .mismatch_cnt (mismatch_cnt),
        .overflow (overflow), .underflow (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish before 2 ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One RUN cycle of tap stimulus. Scoreboard order: the pop sees the
    // FIFO before the push; a push into 8 stored entries is dropped.
    task automatic step(input logic fv, input logic fr, input logic dv, input logic dr);
        bit popped;
        popped     = 1'b0;
        fin_valid  = fv;
        fin_ready  = fr;
        dout_valid = dv;
        dout_ready = dr;
        if (dv && dr && push_q.size() > 0) begin
            exp_lat_q.push_back(cyc_n - push_q.pop_front());
            popped = 1'b1;
        end
        if (fv && fr && push_q.size() < MI) push_q.push_back(cyc_n);
        @(posedge clk);
        #1;
        cyc_n++;
        if (popped) check("lat_last", 64'(lat_last), 64'(exp_lat_q.pop_front()));
        fin_valid  = 1'b0;
        fin_ready  = 1'b0;
        dout_valid = 1'b0;
        dout_ready = 1'b0;
    endtask

    task automatic ctrl(input logic st, input logic cl);
        start = st;
        clear = cl;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        if (cl) begin
            push_q.delete();
            exp_lat_q.delete();
        end
    endtask

    task automatic check_cleared(input string ctx);
        check({ctx, ".running"},    64'(running), 64'(0));
        check({ctx, ".done"},       64'(done), 64'(0));
        check({ctx, ".fin_stall"},  64'(fin_stall_cnt), 64'(0));
        check({ctx, ".fin_idle"},   64'(fin_idle_cnt), 64'(0));
        check({ctx, ".dout_stall"}, 64'(dout_stall_cnt), 64'(0));
        check({ctx, ".dout_idle"},  64'(dout_idle_cnt), 64'(0));
        check({ctx, ".fin_acc"},    64'(fin_accepts), 64'(0));
        check({ctx, ".dout_acc"},   64'(dout_accepts), 64'(0));
        check({ctx, ".lat_last"},   64'(lat_last), 64'(0));
        check({ctx, ".lat_min"},    64'(lat_min), 64'(16'hFFFF));
        check({ctx, ".lat_max"},    64'(lat_max), 64'(0));
        check({ctx, ".lat_total"},  64'(lat_total), 64'(0));
        check({ctx, ".mismatch"},   64'(mismatch_cnt), 64'(0));
        check({ctx, ".overflow"},   64'(overflow), 64'(0));
        check({ctx, ".underflow"},  64'(underflow), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0; target_entries = '0;
        fin_valid = 1'b0; fin_ready = 1'b0; dout_valid = 1'b0; dout_ready = 1'b0;
        labels = '0; exp_labels = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_cleared("reset");

        // Four back-to-back entries, fixed latency 10, target 4.
        target_entries = 4;
        ctrl(1'b1, 1'b0);
        check("t1.running", 64'(running), 64'(1));
        for (int k = 0; k < 14; k++) begin
            step(k < 4, k < 4, k >= 10, k >= 10);
            if (k == 12) check("t1.done_early", 64'(done), 64'(0));
        end
        check("t1.done",      64'(done), 64'(1));
        check("t1.dout_acc",  64'(dout_accepts), 64'(4));
        check("t1.fin_acc",   64'(fin_accepts), 64'(4));
        check("t1.lat_min",   64'(lat_min), 64'(10));
        check("t1.lat_max",   64'(lat_max), 64'(10));
        check("t1.lat_total", 64'(lat_total), 64'(40));
        step(1'b1, 1'b1, 1'b0, 1'b0);  // ignored outside RUN
        check("t1.hold_fin_acc", 64'(fin_accepts), 64'(4));
        ctrl(1'b1, 1'b0);
        check("t1.restart_run", 64'(running), 64'(1));
        check("t1.restart_keep", 64'(dout_accepts), 64'(4));

        // Stall and idle counting on both sides.
        ctrl(1'b0, 1'b1);
        target_entries = 0;
        ctrl(1'b1, 1'b0);
        repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t2.fin_stall", 64'(fin_stall_cnt), 64'(7));
        check("t2.fin_acc",   64'(fin_accepts), 64'(1));
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
        check("t2.fin_idle",  64'(fin_idle_cnt), 64'(3));
        repeat (7) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("t2.dout_stall", 64'(dout_stall_cnt), 64'(7));
        check("t2.dout_acc",   64'(dout_accepts), 64'(1));
        check("t2.lat_11",     64'(lat_last), 64'(11));
        check("t2.underflow",  64'(underflow), 64'(0));
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("t2.dout_idle",  64'(dout_idle_cnt), 64'(2));

        // Overflow on the 9th push, drain 8, then one underflowing pop.
        ctrl(1'b0, 1'b1);
        ctrl(1'b1, 1'b0);
        repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t3.overflow", 64'(overflow), 64'(1));
        check("t3.fin_acc",  64'(fin_accepts), 64'(9));
        repeat (8) step(1'b0, 1'b0, 1'b1, 1'b1);
        check("t3.underflow_drained", 64'(underflow), 64'(0));
        check("t3.lat_max",  64'(lat_max), 64'(9));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("t3.underflow", 64'(underflow), 64'(1));
        check("t3.dout_acc",  64'(dout_accepts), 64'(9));

        // Timer wrap: push when the timer reads 0xFFFE, pop 5 cycles later.
        ctrl(1'b0, 1'b1);
        ctrl(1'b1, 1'b0);
        repeat (65534) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("t4.lat_wrap",  64'(lat_last), 64'(5));
        check("t4.lat_total", 64'(lat_total), 64'(5));

        // clear together with start while running, then async rst mid-entry.
        ctrl(1'b1, 1'b1);
        check_cleared("clear");
        ctrl(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5.pre_rst_acc", 64'(fin_accepts), 64'(1));
        #2 rst = 1'b1;
        #1;
        check_cleared("rst");
        push_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;

        // Label comparison on a single entry.
        ctrl(1'b1, 1'b0);
        labels     = 2'b10;
        exp_labels = 2'b01;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
`ifdef HDC_PERF_LABEL_CHECK_EN
        check("t6.mismatch", 64'(mismatch_cnt), 64'(2));
`else
        check("t6.mismatch", 64'(mismatch_cnt), 64'(0));
`endif
        check("t6.queue_empty", 64'(exp_lat_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
